// File: rtl/mag_window_stats_pkg.sv
// ---------------------------------------------------------------------------
// mag_stats_pkg
//   Shared types and constants for the magnitude window statistics block.
//   - state_t   : top-level control FSM states (accumulating / holding result)
//   - DEF_*     : default sample width and window size
//   - sum_width : width of the running sum, sized so a full window of
//                 all-ones samples cannot overflow it
// ---------------------------------------------------------------------------
package mag_stats_pkg;

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,   // collecting samples of the current window
        S_HOLD = 1'b1    // window result presented, waiting for out_ready
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WIN_LOG2 = 3;

    // 2^WIN_LOG2 samples of DATA_W bits each need DATA_W+WIN_LOG2 bits.
    function automatic int sum_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

    localparam int DEF_SUM_W = DEF_DATA_W + DEF_WIN_LOG2;

endpackage

// File: rtl/mag_window_stats_if.sv
// ---------------------------------------------------------------------------
// mag_window_stats_if
//   Sample input stream, alarm threshold and window-result output stream of
//   mag_window_stats.
//
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The producer holds valid and its data
//   stable until that edge; ready may change freely and never waits on valid.
//
//   Modports:
//     slave  : the statistics block (consumes samples, produces results)
//     master : the environment (produces samples, consumes results)
//
//   Signals:
//     in_valid / in_ready / in_mag          sample stream
//     thresh                                alarm threshold
//     out_valid / out_ready                 result stream handshake
//     out_max / out_min / out_mean / out_alarm  result payload
// ---------------------------------------------------------------------------
interface mag_window_stats_if
    import mag_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mag;
    logic [DATA_W-1:0] thresh;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_mean;
    logic              out_alarm;

    modport slave (
        input  in_valid, in_mag, thresh, out_ready,
        output in_ready, out_valid, out_max, out_min, out_mean, out_alarm
    );

    modport master (
        output in_valid, in_mag, thresh, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_mean, out_alarm
    );

endinterface

// File: rtl/mag_window_acc.sv
// ---------------------------------------------------------------------------
// mag_window_acc
//   Running accumulators for one window: max, min, sum and sample count.
//   The nxt_* outputs are the window statistics *including* the sample on
//   in_mag, so the owner can capture a complete result on the same edge that
//   accepts the last sample.
//
//   Ports:
//     clk, rst  clock, synchronous active-high reset
//     clear     return accumulators to their reset values (wins over accept)
//     accept    fold in_mag into the accumulators
//     in_mag    sample value
//     nxt_max   max(run_max, in_mag)
//     nxt_min   min(run_min, in_mag)
//     nxt_sum   sum + in_mag
//     last      the next accepted sample completes the window
// ---------------------------------------------------------------------------
module mag_window_acc
    import mag_stats_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int SUM_W    = sum_width(DATA_W, WIN_LOG2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] in_mag,
    output logic [DATA_W-1:0] nxt_max,
    output logic [DATA_W-1:0] nxt_min,
    output logic [SUM_W-1:0]  nxt_sum,
    output logic              last
);

    logic [DATA_W-1:0]   run_max;
    logic [DATA_W-1:0]   run_min;
    logic [SUM_W-1:0]    sum;
    logic [WIN_LOG2-1:0] count;

    assign nxt_max = (in_mag > run_max) ? in_mag : run_max;
    assign nxt_min = (in_mag < run_min) ? in_mag : run_min;
    assign nxt_sum = sum + SUM_W'(in_mag);

    // count is exactly WIN_LOG2 bits, so all-ones marks the final sample and
    // the increment past it wraps to zero by itself.
    assign last = &count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_max <= '0;
            run_min <= '1;
            sum     <= '0;
            count   <= '0;
        end else if (accept) begin
            run_max <= nxt_max;
            run_min <= nxt_min;
            sum     <= nxt_sum;
            count   <= count + WIN_LOG2'(1);
        end
    end

endmodule

// File: rtl/mag_window_stats.sv
// ---------------------------------------------------------------------------
// mag_window_stats
//   Collects non-overlapping windows of 2^WIN_LOG2 unsigned magnitude samples
//   and, per window, presents max, min, truncated mean and a threshold alarm
//   (max >= thresh, thresh taken on the window-completing edge).
//   A result appears on out_* one cycle after the last sample of its window
//   and is held stable until out_ready.
//
//   Build option: define MAG_STATS_OVERLAP_EN to keep accepting samples while
//   a result is pending; only the completing sample of the next window stalls
//   until the pending result is taken. Without it, input stalls for the whole
//   time a result is pending.
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     bus        mag_window_stats_if.slave (sample in, thresh, result out)
//     dbg_state  current control FSM state
// ---------------------------------------------------------------------------
module mag_window_stats
    import mag_stats_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                      clk,
    input  logic                      rst,
    mag_window_stats_if.slave         bus,
    output state_t                    dbg_state
);

    localparam int SUM_W = sum_width(DATA_W, WIN_LOG2);

    state_t            state;
    state_t            state_nxt;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              complete;
    logic              last;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;
    logic [SUM_W-1:0]  nxt_sum;
    logic [DATA_W-1:0] res_max;
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_mean;
    logic              res_alarm;

    assign out_valid = (state == S_HOLD);

`ifdef MAG_STATS_OVERLAP_EN
    // A pending result only blocks the sample that would overwrite it.
    assign in_ready = !out_valid || bus.out_ready || !last;
`else
    assign in_ready = !out_valid;
`endif

    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && last;

    mag_window_acc #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2),
        .SUM_W    (SUM_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (complete),
        .accept  (accept),
        .in_mag  (bus.in_mag),
        .nxt_max (nxt_max),
        .nxt_min (nxt_min),
        .nxt_sum (nxt_sum),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC: begin
                if (complete) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // A completing sample here implies the old result is being
                // taken on this same edge, so a new result replaces it.
                if (complete) begin
                    state_nxt = S_HOLD;
                end else if (bus.out_ready) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_max   <= '0;
            res_min   <= '0;
            res_mean  <= '0;
            res_alarm <= 1'b0;
        end else if (complete) begin
            res_max   <= nxt_max;
            res_min   <= nxt_min;
            res_mean  <= DATA_W'(nxt_sum >> WIN_LOG2);
            res_alarm <= (nxt_max >= bus.thresh);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_max   = res_max;
    assign bus.out_min   = res_min;
    assign bus.out_mean  = res_mean;
    assign bus.out_alarm = res_alarm;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mag_window_stats.sv
// ---------------------------------------------------------------------------
// tb_mag_window_stats
//   Bench for mag_window_stats with default parameters. A reference model
//   keeps the accepted samples of the open window in a queue and computes
//   each window result with plain loops and integer division; expected
//   results wait in exp_q until the output handshake takes them.
// ---------------------------------------------------------------------------
module tb_mag_window_stats;
    import mag_stats_pkg::*;

    localparam int DW  = 8;
    localparam int WL  = 3;
    localparam int WIN = 1 << WL;
    localparam int RW  = 3 * DW + 1;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    mag_window_stats_if #(.DATA_W(DW)) bus ();

    mag_window_stats #(
        .DATA_W   (DW),
        .WIN_LOG2 (WL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];          // {alarm, mean, min, max}
    logic [DW-1:0] win_q[$];          // samples of the open window
    logic [RW-1:0] shown;             // value out_* should currently show
    logic          armed;
    int            total;
    int            bad;
    int            ready_mode;        // 0: hold low, 1: hold high, 2: random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] ref_result(input logic [DW-1:0] s[$], input logic [DW-1:0] th);
        int mx;
        int mn;
        int sm;
        logic [DW-1:0] mean;
        logic alarm;
        mx = 0;
        mn = (1 << DW) - 1;
        sm = 0;
        foreach (s[i]) begin
            if (int'(s[i]) > mx) mx = int'(s[i]);
            if (int'(s[i]) < mn) mn = int'(s[i]);
            sm += int'(s[i]);
        end
        mean  = DW'(sm / WIN);
        alarm = (mx >= int'(th));
        return {alarm, mean, DW'(mn), DW'(mx)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [DW-1:0] v, input logic [DW-1:0] th);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_mag   = v;
        bus.thresh   = th;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input int mx, input int mn, input int mean, input int alarm);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_max"},   32'(bus.out_max),   32'(mx));
        check({tag, "_min"},   32'(bus.out_min),   32'(mn));
        check({tag, "_mean"},  32'(bus.out_mean),  32'(mean));
        check({tag, "_alarm"}, 32'(bus.out_alarm), 32'(alarm));
    endtask

    // ---------------- stimulus, monitor, ready driver ----------------
    initial begin
        logic [DW-1:0] seq_a[8];
        logic [DW-1:0] seq_h[8];

        total        = 0;
        bad          = 0;
        armed        = 1'b0;
        shown        = '0;
        ready_mode   = 1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mag   = '0;
        bus.thresh   = '0;
        bus.out_ready = 1'b1;

        fork
            // ready driver
            forever begin
                @(posedge clk);
                #1;
                case (ready_mode)
                    0:       bus.out_ready = 1'b0;
                    1:       bus.out_ready = 1'b1;
                    default: bus.out_ready = 1'($urandom_range(0, 1));
                endcase
            end
            // monitor + reference model; checks reflect the previous edge,
            // the update afterwards predicts the coming edge
            forever begin
                logic          pending;
                logic          exp_ready;
                logic [RW-1:0] cur;
                logic [RW-1:0] r;
                @(negedge clk);
                pending   = (exp_q.size() != 0);
                exp_ready = !pending;
`ifdef MAG_STATS_OVERLAP_EN
                exp_ready = !pending || bus.out_ready || (win_q.size() != WIN - 1);
`endif
                if (armed) begin
                    cur = pending ? exp_q[0] : shown;
                    check("out_valid", 32'(bus.out_valid), 32'(pending));
                    check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
                    check("dbg_state", 32'(dbg_state == S_HOLD), 32'(pending));
                    check("out_max",   32'(bus.out_max),   32'(cur[DW-1:0]));
                    check("out_min",   32'(bus.out_min),   32'(cur[2*DW-1:DW]));
                    check("out_mean",  32'(bus.out_mean),  32'(cur[3*DW-1:2*DW]));
                    check("out_alarm", 32'(bus.out_alarm), 32'(cur[3*DW]));
                end
                if (rst) begin
                    win_q.delete();
                    exp_q.delete();
                    shown = '0;
                    armed = 1'b1;
                end else if (armed) begin
                    if (pending && bus.out_ready) void'(exp_q.pop_front());
                    if (bus.in_valid && exp_ready) begin
                        win_q.push_back(bus.in_mag);
                        if (win_q.size() == WIN) begin
                            r = ref_result(win_q, bus.thresh);
                            exp_q.push_back(r);
                            shown = r;
                            win_q.delete();
                        end
                    end
                end
            end
        join_none

        // reset
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready),  32'd1);
        check("rst_max",   32'(bus.out_max),   32'd0);

        // ascending window, alarm exactly at threshold
        seq_a = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        foreach (seq_a[i]) push(seq_a[i], 8'd80);
        check_out("asc80", 80, 10, 45, 1);
        idle(2);

        // threshold one above max
        foreach (seq_a[i]) push(seq_a[i], 8'd81);
        check_out("asc81", 80, 10, 45, 0);
        idle(2);

        // all ones, thresh 0 always alarms
        for (int i = 0; i < WIN; i++) push(8'd255, 8'd0);
        check_out("ones", 255, 255, 255, 1);
        idle(2);

        // truncated mean
        push(8'd1, 8'd1);
        for (int i = 1; i < WIN; i++) push(8'd0, 8'd1);
        check_out("trunc", 1, 0, 0, 1);
        idle(2);

        // hold with out_ready low, stale samples offered meanwhile
        ready_mode = 0;
        idle(2);
        seq_h = '{8'd100, 8'd5, 8'd60, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
        foreach (seq_h[i]) push(seq_h[i], 8'd200);
        bus.in_valid = 1'b1;
        bus.in_mag   = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out("hold", 100, 5, 26, 0);
`ifndef MAG_STATS_OVERLAP_EN
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
`endif
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        idle(3);
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_ready", 32'(bus.in_ready),  32'd1);

        // partial window discarded by reset
        for (int i = 0; i < 3; i++) push(8'd200, 8'd6);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_max",   32'(bus.out_max),   32'd0);
        for (int i = 0; i < WIN; i++) push(8'd5, 8'd6);
        check_out("after_rst", 5, 5, 5, 0);
        idle(2);

        // gaps between samples
        for (int i = 0; i < WIN; i++) begin
            push(8'd7, 8'd7);
            if (i != WIN - 1) idle(1);
        end
        check_out("gappy", 7, 7, 7, 1);
        idle(2);

        // randomized traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 240; i++) begin
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        ready_mode = 1;
        idle(4);

        // two windows back-to-back against a stalled consumer
        ready_mode = 0;
        idle(2);
        fork
            for (int i = 0; i < 2 * WIN; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            begin
                idle(40);
                ready_mode = 1;
            end
        join
        idle(10);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
